// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM encoding
// and the FIFO entry width helper.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } rx_state_e;

   // Entry layout is {break, frame_err, parity_err, data}.
   function automatic int fifo_entry_w(input int data_bits);
      return data_bits + 3;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with extra-bit pointers; head reads 0 when empty.
// Shared by the receive and transmit paths.
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             i_reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A push into a full FIFO is allowed only when the head leaves on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/rx_uart_fifo.sv
// UART receiver with runtime divisor, parity and stop-bit configuration; each
// character is queued with its parity, framing and break status.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | line idle, waiting for a synced falling edge
// START      | half-bit wait, then confirm the start bit is still low
// DATA       | sampling DATA_BITS bits, LSB first
// PARITY     | sampling the parity bit
// STOP       | sampling one or two stop bits; push on the last one
// WAIT_HIGH  | frame ended with the line low; wait for it to return high
module rx_uart_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int TIMER_BITS = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  i_reset_n,
   input  logic                  uart_txd_in,
   input  logic [TIMER_BITS-1:0] i_div,
   input  logic [1:0]            i_parity,
   input  logic                  i_two_stop,
   input  logic                  i_ready,
   output logic                  out_valid,
   output logic [DATA_BITS-1:0]  out_data,
   output logic                  out_parity_err,
   output logic                  out_frame_err,
   output logic                  out_break,
   output logic                  out_overrun,
   output logic                  out_busy
);

   localparam int EW = fifo_entry_w(DATA_BITS);
   localparam int CW = $clog2(DATA_BITS);

   rx_state_e             state_q, state_d;
   logic [2:0]            sync_q, sync_d;
   logic [TIMER_BITS-1:0] timer_q, timer_d;
   logic [TIMER_BITS-1:0] div_q, div_d;
   logic [1:0]            par_q, par_d;
   logic                  two_stop_q, two_stop_d;
   logic [DATA_BITS-1:0]  shreg_q, shreg_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  par_bit_q, par_bit_d;
   logic                  par_err_q, par_err_d;
   logic                  frame_err_q, frame_err_d;
   logic                  stop1_q, stop1_d;
   logic                  ovr_q, ovr_d;

   logic                  line, fall, tick, par_en, push;
   logic                  frame_now, stop1_now, brk;
   logic [TIMER_BITS-1:0] div_eff;
   logic [EW-1:0]         entry, fifo_head;
   logic                  fifo_full, fifo_empty;

   assign sync_d  = {sync_q[1:0], uart_txd_in};
   assign line    = sync_q[2];
   assign fall    = sync_q[2] && !sync_q[1];
   assign tick    = (timer_q == '0);
   assign par_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
   assign div_eff = (i_div < TIMER_BITS'(2)) ? TIMER_BITS'(2) : i_div;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      div_d       = div_q;
      par_d       = par_q;
      two_stop_d  = two_stop_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      par_bit_d   = par_bit_q;
      par_err_d   = par_err_q;
      frame_err_d = frame_err_q;
      stop1_d     = stop1_q;
      push        = 1'b0;

      // Status of the entry as it would be if this stop sample were the last.
      frame_now = frame_err_q || !line;
      stop1_now = stop_cnt_q ? stop1_q : line;
      brk       = (shreg_q == '0) && (!par_en || !par_bit_q) && !stop1_now;
      entry     = {brk, frame_now || brk, par_err_q, shreg_q};

      if (state_q != ST_IDLE && state_q != ST_WAIT_HIGH) begin
         timer_d = tick ? (div_q - TIMER_BITS'(1)) : (timer_q - TIMER_BITS'(1));
      end

      unique case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d     = ST_START;
               div_d       = div_eff;
               timer_d     = div_eff >> 1;
               par_d       = i_parity;
               two_stop_d  = i_two_stop;
               bit_cnt_d   = '0;
               stop_cnt_d  = 1'b0;
               par_bit_d   = 1'b0;
               par_err_d   = 1'b0;
               frame_err_d = 1'b0;
               stop1_d     = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               if (line) begin
                  state_d = ST_IDLE;
                  timer_d = '0;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shreg_d = {line, shreg_q[DATA_BITS-1:1]};
               if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = par_en ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               par_bit_d = line;
               par_err_d = (^shreg_q) ^ line ^ (par_q == PAR_ODD);
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               frame_err_d = frame_now;
               stop1_d     = stop1_now;
               if (two_stop_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  push    = 1'b1;
                  timer_d = '0;
                  state_d = line ? ST_IDLE : ST_WAIT_HIGH;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (line) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // A full FIFO drops the entry unless the consumer frees a slot on the same edge.
   assign ovr_d = push && fifo_full && !(i_ready && !fifo_empty);

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         sync_q      <= 3'b111;
         timer_q     <= '0;
         div_q       <= TIMER_BITS'(2);
         par_q       <= PAR_NONE;
         two_stop_q  <= 1'b0;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= 1'b0;
         par_bit_q   <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         stop1_q     <= 1'b1;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         timer_q     <= timer_d;
         div_q       <= div_d;
         par_q       <= par_d;
         two_stop_q  <= two_stop_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         par_bit_q   <= par_bit_d;
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
         stop1_q     <= stop1_d;
         ovr_q       <= ovr_d;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .i_reset_n (i_reset_n),
      .push      (push),
      .pop       (i_ready),
      .din       (entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign out_valid      = !fifo_empty;
   assign out_data       = fifo_head[DATA_BITS-1:0];
   assign out_parity_err = fifo_head[DATA_BITS];
   assign out_frame_err  = fifo_head[DATA_BITS+1];
   assign out_break      = fifo_head[DATA_BITS+2];
   assign out_overrun    = ovr_q;
   assign out_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_uart_fifo.sv
// Self-checking bench for rx_uart_fifo: directed frames plus randomized traffic,
// compared every cycle against a queue-based model of the receiver.
module tb_rx_uart_fifo;
   import uart_pkg::*;

   localparam int DB    = 8;
   localparam int TB    = 16;
   localparam int DEPTH = 4;
   localparam int EW    = DB + 3;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          pin   = 1'b1;
   logic [TB-1:0] div   = 16'd16;
   logic [1:0]    par   = 2'b00;
   logic          two   = 1'b0;
   logic          rdy   = 1'b0;

   logic          out_valid, out_parity_err, out_frame_err, out_break, out_overrun, out_busy;
   logic [DB-1:0] out_data;

   rx_uart_fifo #(.DATA_BITS(DB), .TIMER_BITS(TB), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .i_reset_n      (rst_n),
      .uart_txd_in    (pin),
      .i_div          (div),
      .i_parity       (par),
      .i_two_stop     (two),
      .i_ready        (rdy),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_parity_err (out_parity_err),
      .out_frame_err  (out_frame_err),
      .out_break      (out_break),
      .out_overrun    (out_overrun),
      .out_busy       (out_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            vis;
      logic [EW-1:0] ent;
   } sched_t;

   sched_t        sched[$];
   logic [EW-1:0] mq[$];
   bit            pend_pop  = 1'b0;
   bit            exp_ovr   = 1'b0;
   bit            rnd_ready = 1'b0;
   int            strobe_at = -1;
   int            cyc       = 0;
   int            ovr_seen  = 0;
   int            n_checks  = 0;
   int            n_errors  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: pops decided last cycle, pushes scheduled at their spec'd cycle.
   always @(negedge clk) begin
      logic [EW-1:0] head;
      int            was;
      if (!rst_n) begin
         mq.delete();
         pend_pop = 1'b0;
         exp_ovr  = 1'b0;
         chk("reset_busy", {31'd0, out_busy}, 32'd0);
      end else begin
         was     = mq.size();
         exp_ovr = 1'b0;
         if (pend_pop) void'(mq.pop_front());
         if (sched.size() != 0 && sched[0].vis == cyc) begin
            if (was == DEPTH && !pend_pop) exp_ovr = 1'b1;
            else mq.push_back(sched[0].ent);
            void'(sched.pop_front());
         end
      end
      head = (mq.size() != 0) ? mq[0] : '0;
      chk("cycle", {19'd0, out_valid, out_break, out_frame_err, out_parity_err, out_data, out_overrun},
          {19'd0, mq.size() != 0, head, exp_ovr});
      if (out_overrun) ovr_seen++;
      pend_pop = (mq.size() != 0) && rdy;
   end

   task automatic tick1();
      @(posedge clk);
      #1;
      if (rnd_ready) rdy = 1'($urandom_range(0, 1));
      else if (strobe_at >= 0) rdy = (cyc == strobe_at);
   endtask

   task automatic pop_one();
      rdy = 1'b1;
      tick1();
      rdy = 1'b0;
      tick1();
   endtask

   task automatic send_frame(input logic [DB-1:0] data, input int d, input logic [1:0] pm,
                             input bit ts, input bit pflip, input bit [1:0] stop_low,
                             input int gap, input bit strobe, input bit probe, input bit scramble);
      int            de, n, c0, t;
      bit            pen, perr, ferr, brk;
      logic          pb;
      logic          bits[$];
      logic [EW-1:0] ent;
      de  = (d < 2) ? 2 : d;
      pen = (pm == PAR_EVEN) || (pm == PAR_ODD);
      pb  = ((pm == PAR_ODD) ? ~(^data) : (^data)) ^ pflip;
      bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) bits.push_back(data[i]);
      if (pen) bits.push_back(pb);
      bits.push_back(~stop_low[0]);
      if (ts) bits.push_back(~stop_low[1]);
      n    = bits.size();
      perr = pen && ((pm == PAR_EVEN) ? (^data ^ pb) : !(^data ^ pb));
      ferr = stop_low[0] || (ts && stop_low[1]);
      brk  = (data == '0) && (!pen || !pb) && stop_low[0];
      ent  = {brk, ferr || brk, perr, data};
      div  = TB'(d);
      par  = pm;
      two  = ts;
      c0   = cyc;
      t    = 3 + (de >> 1) + 1 + de * (n - 1);
      sched.push_back('{c0 + t, ent});
      strobe_at = strobe ? (c0 + t - 1) : -1;
      if (strobe) rdy = 1'b0;
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < de; j++) begin
            pin = bits[k];
            if (k == 2 && j == 0) begin
               chk("busy_mid", {31'd0, out_busy}, 32'd1);
               if (scramble) begin
                  div = TB'($urandom);
                  par = 2'($urandom);
                  two = 1'($urandom);
               end
            end
            if (probe && cyc == c0 + 155) chk("a5_before_push", {31'd0, out_valid}, 32'd0);
            if (probe && cyc == c0 + 156) chk("a5_at_push", {31'd0, out_valid}, 32'd1);
            tick1();
         end
      end
      pin = 1'b1;
      for (int j = 0; j < gap; j++) tick1();
      strobe_at = -1;
      if (strobe) rdy = 1'b0;
      chk("busy_after_gap", {31'd0, out_busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, out_busy}, 32'd0);
      chk("rst_flags", {29'd0, out_break, out_frame_err, out_parity_err}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_ovr", {31'd0, out_overrun}, 32'd0);
      rst_n = 1'b1;
      repeat (10) tick1();

      // 8N1 0xA5, with pinned push latency
      send_frame(8'hA5, 16, PAR_NONE, 0, 0, 2'b00, 20, 0, 1, 0);
      chk("a5_data", {24'd0, out_data}, 32'h0A5);
      chk("a5_flags", {29'd0, out_break, out_frame_err, out_parity_err}, 32'd0);
      pop_one();
      chk("a5_popped", {31'd0, out_valid}, 32'd0);

      // Parity: 0x41 has two ones, so even mode expects parity bit 0
      send_frame(8'h41, 16, PAR_EVEN, 0, 0, 2'b00, 20, 0, 0, 0);
      chk("even_pb0_err", {31'd0, out_parity_err}, 32'd0);
      pop_one();
      send_frame(8'h41, 16, PAR_EVEN, 0, 1, 2'b00, 20, 0, 0, 0);
      chk("even_pb1_err", {31'd0, out_parity_err}, 32'd1);
      chk("even_pb1_data", {24'd0, out_data}, 32'h41);
      pop_one();
      send_frame(8'h41, 16, PAR_ODD, 0, 1, 2'b00, 20, 0, 0, 1);
      chk("odd_pb0_err", {31'd0, out_parity_err}, 32'd1);
      pop_one();
      send_frame(8'h5A, 16, 2'b11, 0, 0, 2'b00, 20, 0, 0, 0);
      chk("par11_data", {24'd0, out_data}, 32'h5A);
      chk("par11_flags", {29'd0, out_break, out_frame_err, out_parity_err}, 32'd0);
      pop_one();

      // Two stop bits, second low, then a good frame
      send_frame(8'h3C, 16, PAR_NONE, 1, 0, 2'b10, 20, 0, 0, 0);
      chk("stop2_data", {24'd0, out_data}, 32'h3C);
      chk("stop2_flags", {29'd0, out_break, out_frame_err, out_parity_err}, 32'b010);
      pop_one();
      send_frame(8'hC3, 16, PAR_NONE, 1, 0, 2'b00, 20, 0, 0, 0);
      chk("stop2_good", {21'd0, out_break, out_frame_err, out_parity_err, out_data}, 32'h0C3);
      pop_one();

      // Line held low for 20 bit times: one break entry, then silence
      div = 16'd16; par = PAR_NONE; two = 1'b0;
      c0 = cyc;
      pin = 1'b0;
      sched.push_back('{c0 + 156, {1'b1, 1'b1, 1'b0, 8'h00}});
      for (int j = 0; j < 320; j++) begin
         if (j == 240) chk("break_wait_busy", {31'd0, out_busy}, 32'd1);
         tick1();
      end
      pin = 1'b1;
      repeat (40) tick1();
      chk("break_entry", {21'd0, out_break, out_frame_err, out_parity_err, out_data}, 32'h600);
      chk("break_idle", {31'd0, out_busy}, 32'd0);
      pop_one();
      chk("break_single", {31'd0, out_valid}, 32'd0);

      // Overrun: FIFO_DEPTH+1 frames with no consumer
      ovr_seen = 0;
      for (int i = 0; i <= DEPTH; i++)
         send_frame(8'h10 + 8'(i), 16, PAR_NONE, 0, 0, 2'b00, 12, 0, 0, 0);
      chk("ovr_pulses", ovr_seen, 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("ovr_order", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h10 + 8'(i)});
         pop_one();
      end
      chk("ovr_drained", {31'd0, out_valid}, 32'd0);

      // Pop coinciding with the push into a full FIFO
      for (int i = 0; i <= DEPTH; i++)
         send_frame(8'h20 + 8'(i), 16, PAR_NONE, 0, 0, 2'b00, 12, i == DEPTH, 0, 0);
      chk("pop_push_no_ovr", ovr_seen, 32'd1);
      for (int i = 1; i <= DEPTH; i++) begin
         chk("pop_push_order", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h20 + 8'(i)});
         pop_one();
      end
      chk("pop_push_drained", {31'd0, out_valid}, 32'd0);

      // 4-clock glitch is a false start
      div = 16'd16;
      pin = 1'b0;
      repeat (4) tick1();
      pin = 1'b1;
      repeat (60) tick1();
      chk("glitch_valid", {31'd0, out_valid}, 32'd0);
      chk("glitch_busy", {31'd0, out_busy}, 32'd0);

      // Reset mid-frame with an entry pending
      send_frame(8'h77, 16, PAR_NONE, 0, 0, 2'b00, 12, 0, 0, 0);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      pin = 1'b0;
      repeat (40) tick1();
      pin = 1'b1;
      repeat (16) tick1();
      pin = 1'b0;
      repeat (20) tick1();
      rst_n = 1'b0;
      sched.delete();
      #1;
      chk("midrst_outputs", {18'd0, out_valid, out_busy, out_overrun, out_break, out_frame_err,
                             out_parity_err, out_data}, 32'd0);
      repeat (3) tick1();
      pin = 1'b1;
      rst_n = 1'b1;
      repeat (200) tick1();
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, out_busy}, 32'd0);

      // Randomized traffic with a random consumer
      rnd_ready = 1'b1;
      for (int f = 0; f < 30; f++) begin
         logic [DB-1:0] dat;
         bit [1:0]      sl;
         bit            ts;
         dat = ($urandom_range(0, 7) == 0) ? '0 : DB'($urandom);
         ts  = 1'($urandom);
         sl  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (!ts) sl[1] = 1'b0;
         send_frame(dat, $urandom_range(1, 20), 2'($urandom), ts, 1'($urandom), sl,
                    8 + $urandom_range(0, 20), 0, 0, 1'($urandom));
      end
      rnd_ready = 1'b0;
      rdy = 1'b1;
      repeat (20) tick1();
      chk("final_empty", {31'd0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
